// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, pattern mode encodings
// and a small window-decode helper used by the timing generator.
package vga_pkg;

  localparam int unsigned CntW = 11;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;
  localparam int unsigned PIX_W_DEF     = 4;
  localparam int unsigned CHK_LOG2_DEF  = 5;

  localparam logic [2:0] MODE_CHECKER = 3'd0;
  localparam logic [2:0] MODE_WHITE   = 3'd1;
  localparam logic [2:0] MODE_HSPLIT  = 3'd2;
  localparam logic [2:0] MODE_VSPLIT  = 3'd3;
  localparam logic [2:0] MODE_GRAD    = 3'd4;

  // True while lo <= pos < lo + len.
  function automatic logic in_window(input logic [CntW-1:0] pos, input int unsigned lo,
                                     input int unsigned len);
    int unsigned p;
    p = 32'(pos);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video bundle between the pattern generator (master) and a display sink (slave).
interface vga_pattern_gen_if
  import vga_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) ();

  logic [2:0]       mode;
  logic             invert;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [PIX_W-1:0] video;
  logic [CntW-1:0]  x;
  logic [CntW-1:0]  y;
  logic             frame_start;

  modport master (
    input  mode, invert,
    output hsync, vsync, de, video, x, y, frame_start
  );

  modport slave (
    output mode, invert,
    input  hsync, vsync, de, video, x, y, frame_start
  );

endinterface

// File: rtl/vga_timing.sv
// Raster counters plus registered sync/de/position decode. Reusable by any
// color generator that registers its pixel from h_o/v_o with the same latency.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0
) (
  input  logic            clk_25mhz,
  input  logic            reset,
  output logic [CntW-1:0] h_o,
  output logic [CntW-1:0] v_o,
  output logic            active_o,
  output logic            frame_end_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            de_o,
  output logic            frame_start_o,
  output logic [CntW-1:0] x_o,
  output logic [CntW-1:0] y_o
);

  localparam int unsigned HTotal = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [CntW-1:0] HLast = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] VLast = CntW'(VTotal - 1);
  localparam logic [CntW-1:0] HDisp = CntW'(H_DISPLAY);
  localparam logic [CntW-1:0] VDisp = CntW'(V_DISPLAY);

  logic [CntW-1:0] h_q, h_d, v_q, v_d;
  logic [CntW-1:0] x_q, x_d, y_q, y_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic            de_q, de_d, fs_q, fs_d;
  logic            h_end, v_end;

  always_comb begin
    h_end = (h_q == HLast);
    v_end = (v_q == VLast);
    h_d   = h_end ? '0 : h_q + 1'b1;
    v_d   = v_q;
    if (h_end) begin
      v_d = v_end ? '0 : v_q + 1'b1;
    end
    de_d    = (h_q < HDisp) && (v_q < VDisp);
    hsync_d = in_window(h_q, H_DISPLAY + H_FP, H_SYNC) ? H_POL : ~H_POL;
    vsync_d = in_window(v_q, V_DISPLAY + V_FP, V_SYNC) ? V_POL : ~V_POL;
    fs_d    = (h_q == '0) && (v_q == '0);
    x_d     = de_d ? h_q : '0;
    y_d     = de_d ? v_q : '0;
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  // Unregistered counter state, so a generator can register its pixel alongside ours.
  assign h_o         = h_q;
  assign v_o         = v_q;
  assign active_o    = de_d;
  assign frame_end_o = h_end && v_end;

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
  assign x_o           = x_q;
  assign y_o           = y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: frame-latched mode/invert select, registered video
// aligned with the timing outputs of vga_timing.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0,
  parameter int unsigned PIX_W     = PIX_W_DEF,
  parameter int unsigned CHK_LOG2  = CHK_LOG2_DEF
) (
  input logic              clk_25mhz,
  input logic              reset,
  vga_pattern_gen_if.master vga
);

  // Gradient spans the 1024-wide h range over 2^PIX_W levels.
  localparam int unsigned GradShift = (PIX_W >= 10) ? 0 : 10 - PIX_W;

  localparam logic [CntW-1:0] HHalf = CntW'(H_DISPLAY / 2);
  localparam logic [CntW-1:0] VHalf = CntW'(V_DISPLAY / 2);

  logic [CntW-1:0]  h, v;
  logic             active, frame_end;
  logic [2:0]       mode_q, mode_d;
  logic             invert_q, invert_d;
  logic [PIX_W-1:0] pat, video_d, video_q;

  vga_timing #(
    .H_DISPLAY (H_DISPLAY),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_DISPLAY (V_DISPLAY),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .H_POL     (H_POL),
    .V_POL     (V_POL)
  ) u_timing (
    .clk_25mhz     (clk_25mhz),
    .reset         (reset),
    .h_o           (h),
    .v_o           (v),
    .active_o      (active),
    .frame_end_o   (frame_end),
    .hsync_o       (vga.hsync),
    .vsync_o       (vga.vsync),
    .de_o          (vga.de),
    .frame_start_o (vga.frame_start),
    .x_o           (vga.x),
    .y_o           (vga.y)
  );

  always_comb begin
    // Selects only change on the last pixel, so a frame is never mixed.
    mode_d   = mode_q;
    invert_d = invert_q;
    if (frame_end) begin
      mode_d   = vga.mode;
      invert_d = vga.invert;
    end

    pat = '0;
    case (mode_q)
      MODE_CHECKER: pat = {PIX_W{h[CHK_LOG2] ^ v[CHK_LOG2]}};
      MODE_WHITE:   pat = '1;
      MODE_HSPLIT:  pat = {PIX_W{h < HHalf}};
      MODE_VSPLIT:  pat = {PIX_W{v < VHalf}};
      MODE_GRAD:    pat = PIX_W'(h >> GradShift);
      default:      pat = '0;
    endcase

    video_d = active ? (pat ^ {PIX_W{invert_q}}) : '0;
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_CHECKER;
      invert_q <= 1'b0;
      video_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      invert_q <= invert_d;
      video_q  <= video_d;
    end
  end

  assign vga.video = video_q;

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_DISPLAY, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_DISPLAY, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- PIX_W, 4, video bits (1 = black/white)
- CHK_LOG2, 5, checker square size is 2^CHK_LOG2 pixels

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_25mhz, in, 1, pixel clock
- reset, in, 1, reset; asynchronous, active-high
- mode, in, 3, pattern select
- invert, in, 1, invert video
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, active-video flag
- video, out, PIX_W, pixel intensity
- x, out, 11, pixel column
- y, out, 11, pixel line
- frame_start, out, 1, one-cycle pulse at pixel (0,0)

Function
REQ-003 SHALL derive H_TOTAL as the sum of the four horizontal parameters (800) and V_TOTAL as the sum of the four vertical parameters (525).
REQ-004 SHALL count h from 0 to H_TOTAL-1 and wrap it to 0.
REQ-005 SHALL advance v only on the h wrap, counting 0 to V_TOTAL-1 and wrapping to 0.
REQ-006 SHALL register every output, so each output reflects the counter state of the previous cycle (latency 1) and all outputs are mutually aligned.
REQ-007 SHALL drive hsync = H_POL while H_DISPLAY+H_FP <= h < H_DISPLAY+H_FP+H_SYNC, and !H_POL otherwise.
REQ-008 SHALL drive vsync the same way from v, V_DISPLAY+V_FP and V_SYNC, with level V_POL.
REQ-009 SHALL drive de = 1 when h < H_DISPLAY and v < V_DISPLAY.
REQ-010 SHALL drive x = h and y = v while de = 1, and hold x = 0, y = 0 otherwise.
REQ-011 SHALL pulse frame_start for exactly one cycle per frame, coincident with de rising at h = 0, v = 0.
REQ-012 SHALL sample mode and invert into shadow registers only on the cycle h = H_TOTAL-1, v = V_TOTAL-1; a change mid-frame never alters the current frame.
REQ-013 SHALL compute the pattern P from the shadow mode:
- 0: all-ones if h[CHK_LOG2] XOR v[CHK_LOG2], else 0
- 1: all-ones
- 2: all-ones if h < H_DISPLAY/2
- 3: all-ones if v < V_DISPLAY/2
- 4: gradient = (h >> (10-PIX_W)) truncated to PIX_W bits
- 5 to 7: 0
REQ-014 SHALL output video = P XOR {PIX_W{invert_shadow}} while de = 1, and 0 while de = 0 (blanking is always black, regardless of invert).
REQ-015 SHALL, when PIX_W = 1, give mode 4 the value h[9].

Reset
REQ-016 SHALL, while reset is high, force h, v, x, y and the shadow registers to 0.
REQ-017 SHALL, while reset is high, force de, video and frame_start to 0, hsync to !H_POL and vsync to !V_POL.
REQ-018 SHALL treat reset asserted mid-frame as an immediate abort, and restart from h = 0, v = 0 on the first edge after release.
REQ-019 SHALL produce frame_start on the first cycle after reset release, because the counter is already at (0,0).

Structure
REQ-020 SHALL place the default timing constants and the mode encodings (MODE_CHECKER, MODE_WHITE, MODE_HSPLIT, MODE_VSPLIT, MODE_GRAD) in the shared package vga_pkg.
REQ-021 SHALL implement the counters and sync/de decode in one sub-module, vga_timing, which pattern logic instantiates; vga_timing is reusable by later color generators.

Verification
REQ-022 Default parameters, reset released -> hsync low for exactly 96 cycles every 800 cycles, first falling edge 657 cycles after release; vsync low for exactly 1600 cycles every 420000 cycles.
REQ-023 mode = 0, invert = 0 -> video = 4'hF at (32,0), 4'h0 at (32,32), 4'h0 at (0,0); de = 0 and video = 0 at h = 700.
REQ-024 mode switched 0 -> 1 at v = 100 -> frame remains checker through v = 479; next frame_start pixel shows 4'hF.
REQ-025 mode = 4, PIX_W = 4 -> video = 0 at x = 0, 9 at x = 639; with invert = 1 video = 4'hF at x = 0, while blanking stays 0.
REQ-026 H_POL = 1, V_POL = 1 -> hsync/vsync reset to 0 and pulse high; reset pulsed at v = 200 -> all outputs take reset values asynchronously, and frame_start fires one cycle after release.
